// File: rtl/obi_lsu_initiator.sv
// rtl/obi_lsu_initiator.sv - req/gnt/rvalid initiator with in-order response FIFO and credit control
module obi_lsu_initiator #(
  parameter int OUTSTANDING_MAX = 4,
  parameter int ADDR_W          = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic                               cmd_we_i,
  input  logic [ADDR_W-1:0]                  cmd_addr_i,
  input  logic [3:0]                         cmd_be_i,
  input  logic [31:0]                        cmd_wdata_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [31:0]                        rsp_rdata_o,
  output logic                               rsp_we_o,
  output logic                               data_req_o,
  output logic [ADDR_W-1:0]                  data_addr_o,
  output logic                               data_we_o,
  output logic [3:0]                         data_be_o,
  output logic [31:0]                        data_wdata_o,
  input  logic                               data_gnt_i,
  input  logic                               data_rvalid_i,
  input  logic [31:0]                        data_rdata_i,
  output logic [$clog2(OUTSTANDING_MAX):0]   outstanding_o,
  output logic                               err_o
);

  localparam int PW = $clog2(OUTSTANDING_MAX);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_C = CW'(OUTSTANDING_MAX);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  // Request register (single entry)
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  // Counters and sticky error
  logic [CW-1:0] credit_q;
  logic [CW-1:0] gnt_cnt_q;
  logic          err_q;

  // we-tag FIFO: one entry per granted transaction awaiting rvalid
  logic          tag_mem_q [OUTSTANDING_MAX];
  logic [PW-1:0] tag_wp_q;
  logic [PW-1:0] tag_rp_q;

  // Response FIFO
  logic [31:0]   rsp_data_mem_q [OUTSTANDING_MAX];
  logic          rsp_we_mem_q   [OUTSTANDING_MAX];
  logic [PW-1:0] rsp_wp_q;
  logic [PW-1:0] rsp_rp_q;
  logic [CW-1:0] rsp_cnt_q;

  logic accept;
  logic handshake;
  logic rvalid_ok;
  logic rsp_pop;

  // A pending request may be replaced in the same cycle it is granted
  assign cmd_ready_o = ~reset & (~req_q | data_gnt_i) & (credit_q < MAX_C);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign handshake   = req_q & data_gnt_i;
  // Responses with nothing granted are spurious: flagged, never queued
  assign rvalid_ok   = data_rvalid_i & (gnt_cnt_q != '0);
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;

  assign data_req_o    = req_q;
  assign data_addr_o   = addr_q;
  assign data_we_o     = we_q;
  assign data_be_o     = be_q;
  assign data_wdata_o  = wdata_q;
  assign outstanding_o = credit_q;
  assign err_o         = err_q;

  // Response outputs read 0 when the FIFO is empty so stale storage never leaks
  assign rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? rsp_data_mem_q[rsp_rp_q] : 32'h0;
  assign rsp_we_o    = rsp_valid_o & rsp_we_mem_q[rsp_rp_q];

  // Request register: load on accept, drop after a grant with no replacement
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req_q   <= 1'b1;
      addr_q  <= cmd_addr_i;
      we_q    <= cmd_we_i;
      be_q    <= cmd_be_i;
      wdata_q <= cmd_wdata_i;
    end else if (handshake) begin
      req_q   <= 1'b0;
    end
  end

  // Credit, granted-count and sticky error bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_q  <= '0;
      gnt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept && !rsp_pop) begin
        credit_q <= credit_q + ONE_C;
      end else if (!accept && rsp_pop) begin
        credit_q <= credit_q - ONE_C;
      end
      if (handshake && !rvalid_ok) begin
        gnt_cnt_q <= gnt_cnt_q + ONE_C;
      end else if (!handshake && rvalid_ok) begin
        gnt_cnt_q <= gnt_cnt_q - ONE_C;
      end
      if (data_rvalid_i && (gnt_cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // we-tag FIFO: push on grant, pop when the matching response arrives
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_wp_q <= '0;
      tag_rp_q <= '0;
    end else begin
      if (handshake) begin
        tag_mem_q[tag_wp_q] <= we_q;
        tag_wp_q            <= tag_wp_q + ONE_P;
      end
      if (rvalid_ok) begin
        tag_rp_q <= tag_rp_q + ONE_P;
      end
    end
  end

  // Response FIFO: capture rvalid one cycle before it shows at rsp_valid_o
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wp_q  <= '0;
      rsp_rp_q  <= '0;
      rsp_cnt_q <= '0;
    end else begin
      if (rvalid_ok) begin
        rsp_data_mem_q[rsp_wp_q] <= tag_mem_q[tag_rp_q] ? 32'h0 : data_rdata_i;
        rsp_we_mem_q[rsp_wp_q]   <= tag_mem_q[tag_rp_q];
        rsp_wp_q                 <= rsp_wp_q + ONE_P;
      end
      if (rsp_pop) begin
        rsp_rp_q <= rsp_rp_q + ONE_P;
      end
      if (rvalid_ok && !rsp_pop) begin
        rsp_cnt_q <= rsp_cnt_q + ONE_C;
      end else if (!rvalid_ok && rsp_pop) begin
        rsp_cnt_q <= rsp_cnt_q - ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_obi_lsu_initiator.sv
// tb/tb_obi_lsu_initiator.sv - scoreboard bench with randomized responder for obi_lsu_initiator
module tb_obi_lsu_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_we_o;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic [2:0]  outstanding_o;
  logic        err_o;

  obi_lsu_initiator #(.OUTSTANDING_MAX(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_we_o(rsp_we_o),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Responder / stimulus knobs
  int gnt_pct = 100;
  int rv_min  = 1;
  int rv_max  = 1;
  int rr_pct  = 100;
  bit spur_req = 1'b0;
  int cyc = 0;

  typedef struct { logic we; logic [31:0] rdata; logic [31:0] addr; } exp_t;
  exp_t exp_q[$];

  typedef struct { logic [31:0] data; int due; } pend_t;
  pend_t pend_q[$];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bfm_mem [logic [31:0]];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Unwritten memory returns an address-derived pattern
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Reference model: byte-wise merge of writes, word reads
  function automatic logic [31:0] ref_access(input logic we, input logic [31:0] a,
                                             input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w;
    w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    if (!we) return w;
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    ref_mem[a] = w;
    return 32'h0;
  endfunction

  // Memory responder: random grant, in-order rvalid with random latency >= 1 cycle
  always @(negedge clk) begin
    logic [31:0] old, mask;
    data_gnt_i = ($urandom_range(99) < gnt_pct);
    if (spur_req) begin
      data_rvalid_i = 1'b1;
      data_rdata_i  = $urandom;
      spur_req      = 1'b0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      data_rvalid_i = 1'b1;
      data_rdata_i  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else begin
      data_rvalid_i = 1'b0;
      data_rdata_i  = $urandom;
    end
    #1;
    if (reset) begin
      pend_q.delete();
    end else if (data_req_o && data_gnt_i) begin
      old = bfm_mem.exists(data_addr_o) ? bfm_mem[data_addr_o] : init_word(data_addr_o);
      if (data_we_o) begin
        mask = {{8{data_be_o[3]}}, {8{data_be_o[2]}}, {8{data_be_o[1]}}, {8{data_be_o[0]}}};
        bfm_mem[data_addr_o] = (old & ~mask) | (data_wdata_o & mask);
        pend_q.push_back('{data: $urandom, due: cyc + 1 + $urandom_range(rv_max - rv_min) + rv_min - 1});
      end else begin
        pend_q.push_back('{data: old, due: cyc + 1 + $urandom_range(rv_max - rv_min) + rv_min - 1});
      end
    end
    cyc++;
  end

  // Response back-pressure
  always @(negedge clk) rsp_ready_i = ($urandom_range(99) < rr_pct);

  // Monitor: protocol-level models of credits, granted count, queued responses and error
  int  m_cred = 0, m_gnt = 0, m_avail = 0;
  bit  m_err = 1'b0, stab_v = 1'b0;
  logic [69:0] stab_val;
  always @(negedge clk) begin
    exp_t e;
    bit acc, pop, hs, legit;
    #2;
    chk("outstanding", 96'(outstanding_o), 96'(m_cred));
    chk("err", 96'(err_o), 96'(m_err));
    chk("rsp_valid_latency", 96'(rsp_valid_o), 96'(m_avail > 0));
    if (stab_v) chk("req_stable", 96'({data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o}), 96'(stab_val));
    if (reset) begin
      m_cred = 0; m_gnt = 0; m_avail = 0; m_err = 1'b0; stab_v = 1'b0;
      exp_q.delete();
    end else begin
      acc   = cmd_valid_i & cmd_ready_o;
      pop   = rsp_valid_o & rsp_ready_i;
      hs    = data_req_o & data_gnt_i;
      legit = data_rvalid_i && (m_gnt > 0);
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 96'(1), 96'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_we", 96'(rsp_we_o), 96'(e.we));
          chk("rsp_rdata", 96'(rsp_rdata_o), 96'(e.rdata));
        end
      end
      if (data_rvalid_i && m_gnt == 0) m_err = 1'b1;
      m_gnt   = m_gnt + int'(hs) - int'(legit);
      m_avail = m_avail + int'(legit) - int'(pop);
      m_cred  = m_cred + int'(acc) - int'(pop);
      stab_v  = data_req_o & ~data_gnt_i;
      stab_val = {data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o};
    end
  end

  // Offer one command for up to 'bound' cycles; call at a negedge, returns at a negedge
  task automatic try_send(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int bound, output bit ok, output int waited);
    ok = 1'b0; waited = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_be_i = be; cmd_wdata_i = wd;
    while (waited < bound) begin
      #1;
      if (cmd_ready_o) begin
        exp_q.push_back('{we: we, rdata: ref_access(we, a, be, wd), addr: a});
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic send(input logic we, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int waited);
    bit ok;
    try_send(we, a, be, wd, 500, ok, waited);
    if (!ok) chk("send_timeout", 96'(0), 96'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) chk("drain_timeout", 96'(exp_q.size()), 96'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w, tot, nacc;
    bit ok;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_req", 96'(data_req_o), 96'(0));
    chk("reset_rsp_valid", 96'(rsp_valid_o), 96'(0));
    chk("reset_outstanding", 96'(outstanding_o), 96'(0));
    chk("reset_err", 96'(err_o), 96'(0));
    chk("reset_cmd_ready", 96'(cmd_ready_o), 96'(0));
    @(negedge clk); reset = 1'b0;

    // Write then read back the same word
    send(1'b1, 32'h2600, 4'hF, 32'hDEAD_BEEF, w);
    send(1'b0, 32'h2600, 4'hF, 32'h0, w);
    drain();

    // Grant withheld: request held stable, no further command accepted
    gnt_pct = 0; repeat (2) @(negedge clk);
    send(1'b1, 32'h3000, 4'h5, 32'h1234_5678, w);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h3004;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("held_req", 96'({data_req_o, data_addr_o, data_we_o, data_be_o}), 96'({1'b1, 32'h3000, 1'b1, 4'h5}));
      chk("held_cmd_ready", 96'(cmd_ready_o), 96'(0));
      @(negedge clk);
    end
    cmd_valid_i = 1'b0; gnt_pct = 100;
    send(1'b0, 32'h3004, 4'hF, 32'h0, w);
    send(1'b0, 32'h3000, 4'hF, 32'h0, w);
    drain();

    // Credit limit with responses back-pressured
    rr_pct = 0; rv_min = 1; rv_max = 3; repeat (2) @(negedge clk);
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      try_send(1'b0, 32'h4000 + 32'(4 * i), 4'hF, 32'h0, 20, ok, w);
      nacc += int'(ok);
    end
    try_send(1'b0, 32'h4010, 4'hF, 32'h0, 10, ok, w);
    nacc += int'(ok);
    #3;
    chk("credit_accepted", 96'(nacc), 96'(4));
    chk("credit_outstanding", 96'(outstanding_o), 96'(4));
    chk("credit_cmd_ready", 96'(cmd_ready_o), 96'(0));
    @(negedge clk);
    rr_pct = 100;
    for (int i = 4; i < 8; i++) send(1'b0, 32'h4000 + 32'(4 * i), 4'hF, 32'h0, w);
    drain();

    // Zero-delay grant: one request per cycle
    gnt_pct = 100; rv_min = 1; rv_max = 1; rr_pct = 100; repeat (2) @(negedge clk);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'($urandom_range(1)), 32'h100 + 32'(4 * $urandom_range(7)), 4'($urandom), $urandom, w);
      tot += w;
    end
    chk("back_to_back_stalls", 96'(tot), 96'(0));
    drain();

    // Randomized traffic with address reuse
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 0) begin
        gnt_pct = $urandom_range(100, 30); rr_pct = $urandom_range(100, 30);
        rv_min = 1; rv_max = $urandom_range(5, 1);
      end
      send(1'($urandom_range(1)), 32'h100 + 32'(4 * $urandom_range(7)), 4'($urandom), $urandom, w);
      if ($urandom_range(3) == 0) @(negedge clk);
    end
    gnt_pct = 100; rr_pct = 100;
    drain();

    // Spurious response: sticky error, nothing queued
    spur_req = 1'b1;
    for (int n = 0; n < 5; n++) begin @(negedge clk); #1; if (!spur_req) break; end
    @(negedge clk); #3;
    chk("spur_err", 96'(err_o), 96'(1));
    chk("spur_no_rsp", 96'(rsp_valid_o), 96'(0));
    repeat (3) @(negedge clk);
    #3 chk("spur_err_sticky", 96'(err_o), 96'(1));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #3 chk("spur_err_cleared", 96'(err_o), 96'(0));
    @(negedge clk);

    // Reset with reads in flight and a request pending
    gnt_pct = 100; rv_min = 30; rv_max = 30; repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send(1'b0, 32'h5000 + 32'(4 * i), 4'hF, 32'h0, w);
    @(negedge clk); gnt_pct = 0; @(negedge clk);
    send(1'b0, 32'h500C, 4'hF, 32'h0, w);
    #3 chk("pre_reset_req", 96'(data_req_o), 96'(1));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #3;
    chk("mid_reset_outputs", 96'({data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, rsp_valid_o, rsp_rdata_o}), 96'(0));
    chk("mid_reset_outstanding", 96'(outstanding_o), 96'(0));
    chk("mid_reset_err", 96'(err_o), 96'(0));
    @(negedge clk);
    gnt_pct = 100; rv_min = 1; rv_max = 3; repeat (2) @(negedge clk);
    send(1'b0, 32'h2600, 4'hF, 32'h0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
